// File: rtl/yctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcode classes,
// ALU ops, PC-select and error codes.
package yctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LD  = 3'd2,
    CLS_ST  = 3'd3,
    CLS_BR  = 3'd4,
    CLS_JAL = 3'd5
  } cls_e;

  localparam logic [6:0] OPC_R   = 7'h33;
  localparam logic [6:0] OPC_I   = 7'h13;
  localparam logic [6:0] OPC_LD  = 7'h03;
  localparam logic [6:0] OPC_ST  = 7'h23;
  localparam logic [6:0] OPC_BR  = 7'h63;
  localparam logic [6:0] OPC_JAL = 7'h6F;
  localparam logic [31:0] IR_ECALL = 32'h0000_0073;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JT  = 2'b10;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ILL  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

endpackage

// File: rtl/yctrl_decode.sv
// Combinational instruction classifier: opcode/funct3/funct7 -> class, ALU op,
// illegal flag, and the ecall halt request.
module yctrl_decode
  import yctrl_pkg::*;
(
  input  logic [31:0] ir,
  output cls_e        cls,
  output logic [2:0]  alu_op,
  output logic        illegal,
  output logic        sys_halt
);

  always_comb begin
    cls      = CLS_I;
    alu_op   = ALU_ADD;
    illegal  = 1'b0;
    sys_halt = (ir == IR_ECALL);
    case (ir[6:0])
      OPC_R: begin
        cls = CLS_R;
        case ({ir[31:25], ir[14:12]})
          10'b0000000_000: alu_op = ALU_ADD;
          10'b0100000_000: alu_op = ALU_SUB;
          10'b0000000_111: alu_op = ALU_AND;
          10'b0000000_110: alu_op = ALU_OR;
          10'b0000000_010: alu_op = ALU_SLT;
          default:         illegal = 1'b1;
        endcase
      end
      OPC_I:   cls = CLS_I;
      OPC_LD:  cls = CLS_LD;
      OPC_ST:  cls = CLS_ST;
      OPC_BR: begin
        cls    = CLS_BR;
        alu_op = ALU_SUB;
      end
      OPC_JAL: cls = CLS_JAL;
      default: illegal = !sys_halt;
    endcase
  end

endmodule

// File: rtl/yctrl_multicycle.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/[MEM]/[WB] per instruction, with
// dm_ready handshake, MEM watchdog, illegal-opcode trap and retire-count halt.
module yctrl_multicycle
  import yctrl_pkg::*;
#(
  parameter int MAX_INSTR   = 11,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic             dm_ready,
  output logic             ir_write,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [2:0]       op,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Mem2Reg,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [31:0]      ir_q, ir_d;
  logic [1:0]       err_q, err_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  cls_e       dec_cls;
  logic [2:0] dec_op;
  logic       dec_illegal;
  logic       dec_halt;

  yctrl_decode u_decode (
    .ir       (ir_q),
    .cls      (dec_cls),
    .alu_op   (dec_op),
    .illegal  (dec_illegal),
    .sys_halt (dec_halt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cls_q    <= CLS_I;
      alu_op_q <= ALU_ADD;
      ir_q     <= '0;
      err_q    <= ERR_NONE;
      wd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      alu_op_q <= alu_op_d;
      ir_q     <= ir_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    alu_op_d = alu_op_q;
    ir_d     = ir_q;
    err_d    = err_q;
    wd_d     = '0;
    cnt_d    = cnt_q;
    retire   = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        ir_d    = ins;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        cls_d    = dec_cls;
        alu_op_d = dec_op;
        if (dec_halt) begin
          state_d = ST_HALT;
        end else if (dec_illegal) begin
          state_d = ST_HALT;
          err_d   = ERR_ILL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_LD, CLS_ST: state_d = ST_MEM;
          CLS_BR:         retire  = 1'b1;
          default:        state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        // A ready arriving on the last allowed cycle still wins over the watchdog.
        if (dm_ready) begin
          if (cls_q == CLS_LD) state_d = ST_WB;
          else                 retire  = 1'b1;
        end else if (wd_q == WD_W'(MEM_TIMEOUT - 1)) begin
          state_d = ST_HALT;
          err_d   = ERR_TMO;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_WB:   retire = 1'b1;
      default: state_d = ST_HALT;
    endcase
    if (retire) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (MAX_INSTR != 0 && cnt_d == CNT_W'(MAX_INSTR)) ? ST_HALT : ST_FETCH;
    end
  end

  always_comb begin
    ir_write = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    op       = ALU_ADD;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Mem2Reg  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = PC_SEQ;
    case (state_q)
      ST_FETCH: ir_write = 1'b1;
      ST_EXEC: begin
        op     = alu_op_q;
        ALUSrc = (cls_q == CLS_I || cls_q == CLS_LD || cls_q == CLS_ST);
        if (cls_q == CLS_BR) begin
          pc_write = 1'b1;
          pc_sel   = zero ? PC_BR : PC_SEQ;
        end
        if (cls_q == CLS_JAL) pc_sel = PC_JT;
      end
      ST_MEM: begin
        ALUSrc   = 1'b1;
        op       = alu_op_q;
        MemRead  = (cls_q == CLS_LD);
        MemWrite = (cls_q == CLS_ST);
        pc_write = (cls_q == CLS_ST) && dm_ready;
      end
      ST_WB: begin
        // ALU controls stay put so the writeback value z remains stable.
        op       = alu_op_q;
        ALUSrc   = (cls_q == CLS_I || cls_q == CLS_LD);
        RegWrite = 1'b1;
        Mem2Reg  = (cls_q == CLS_LD);
        pc_write = 1'b1;
        pc_sel   = (cls_q == CLS_JAL) ? PC_JT : PC_SEQ;
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted      = (state_q == ST_HALT);
  assign err         = err_q;
  assign instr_count = cnt_q;

endmodule
